// File: rtl/flasher_pkg.sv
// Shared types and constants for the bound-flasher scheduler.
// Optional macro FLASHER_SCHED_FIXED_PRIO_EN is consumed by flasher_scheduler.
package flasher_pkg;

    localparam int unsigned LED_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StGap   = 2'd3
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flasher_prescaler.sv
// Free-running step divider: one-cycle step_o every PRESCALE enabled clocks.
// clr_i restarts the count so the next step lands PRESCALE clocks later.
module flasher_prescaler
    import flasher_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int unsigned CntW = clog2_min1(PRESCALE);
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        step_o = 1'b0;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d  = '0;
            step_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flasher_scheduler.sv
// Two-requester job scheduler in front of the 16-LED bound flasher.
// Define FLASHER_SCHED_FIXED_PRIO_EN for strict A-over-B priority instead of round robin.
module flasher_scheduler
    import flasher_pkg::*;
#(
    parameter int unsigned PRESCALE      = 4,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned GAP_STEPS     = 2,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [CNT_W-1:0] runs_a,
    input  logic [CNT_W-1:0] runs_b,
    input  logic [LED_W-1:0] led,
    output logic             step_en,
    output logic             flick,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             err
);

    localparam int unsigned ToW  = clog2_min1(START_TIMEOUT + 1);
    localparam int unsigned GapW = clog2_min1(GAP_STEPS + 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] run_cnt_d, run_cnt_q;
    logic [ToW-1:0]   to_cnt_d, to_cnt_q;
    logic [GapW-1:0]  gap_cnt_d, gap_cnt_q;
    logic             seen_nz_d, seen_nz_q;
    logic             owner_d, owner_q;
    logic             gnt_a_d, gnt_a_q;
    logic             gnt_b_d, gnt_b_q;
    logic             done_d, done_q;
    logic             err_d, err_q;
    logic             pick_b;
    logic [CNT_W-1:0] runs_sel;

    flasher_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (state_q != StIdle),
        .clr_i  (gnt_a_q | gnt_b_q),
        .step_o (step_en)
    );

`ifdef FLASHER_SCHED_FIXED_PRIO_EN
    assign pick_b = !req_a;
`else
    logic last_d, last_q;

    // On a tie, B wins only if A was the previous winner.
    assign pick_b = req_b && (!req_a || (last_q == ID_A));

    always_comb begin
        last_d = last_q;
        if ((state_q == StIdle) && (req_a || req_b)) begin
            last_d = pick_b ? ID_B : ID_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ID_B;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        seen_nz_d = seen_nz_q;
        owner_d   = owner_q;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        runs_sel  = pick_b ? runs_b : runs_a;

        case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    state_d   = StStart;
                    owner_d   = pick_b ? ID_B : ID_A;
                    gnt_a_d   = !pick_b;
                    gnt_b_d   = pick_b;
                    run_cnt_d = (runs_sel == '0) ? CNT_W'(1) : runs_sel;
                    to_cnt_d  = '0;
                    seen_nz_d = 1'b0;
                end
            end
            StStart: begin
                if (step_en) begin
                    if (led != '0) begin
                        state_d   = StRun;
                        seen_nz_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                        if (to_cnt_d == ToW'(START_TIMEOUT)) begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            StRun: begin
                if (step_en) begin
                    if (led != '0) begin
                        seen_nz_d = 1'b1;
                    end else if (seen_nz_q) begin
                        seen_nz_d = 1'b0;
                        run_cnt_d = run_cnt_q - 1'b1;
                        if (run_cnt_d == '0) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (GAP_STEPS == 0) begin
                            state_d  = StStart;
                            to_cnt_d = '0;
                        end else begin
                            state_d   = StGap;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end
            StGap: begin
                if (step_en) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == GapW'(GAP_STEPS)) begin
                        state_d  = StStart;
                        to_cnt_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            run_cnt_q <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            seen_nz_q <= 1'b0;
            owner_q   <= ID_A;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            seen_nz_q <= seen_nz_d;
            owner_q   <= owner_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign flick = (state_q == StStart);
    assign busy  = (state_q != StIdle);
    assign owner = owner_q;
    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
